// File: rtl/sale_terminal_pkg.sv
// Shared types and sizes for the sale terminal keypad path.
package sale_terminal_pkg;

  localparam int unsigned KEY_N = 16;
  localparam int unsigned KEY_W = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    OFFER,
    RELEASE
  } kp_state_t;

endpackage

// File: rtl/onehot_encoder16x4.sv
// Combinational 16-to-4 encoder with a popcount==1 flag.
module onehot_encoder16x4
  import sale_terminal_pkg::*;
(
  input  logic [KEY_N-1:0] pattern,
  output logic [KEY_W-1:0] code,
  output logic             onehot
);

  localparam int unsigned ONES_W = $clog2(KEY_N + 1);

  logic [ONES_W-1:0] ones;

  // OR together the indices of set bits; exact only when a single bit is set.
  always_comb begin
    code = '0;
    ones = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (pattern[i]) begin
        code = code | KEY_W'(i);
        ones = ones + ONES_W'(1);
      end
    end
  end

  assign onehot = (ones == ONES_W'(1));

endmodule

// File: rtl/keypad_encoder.sv
// Debounces 16 raw key lines and offers one 4-bit key code per press on a
// valid/ready handshake; multi-key patterns produce a one-cycle error pulse.
module keypad_encoder
  import sale_terminal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_N-1:0] keys_in,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             multi_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_N-1:0] kmeta;
  logic [KEY_N-1:0] ksync;
  logic [KEY_N-1:0] snapshot;
  logic [CNT_W-1:0] cnt;
  kp_state_t        state;
  key_code_t        snap_code;
  logic             snap_onehot;

  onehot_encoder16x4 u_enc (
    .pattern (snapshot),
    .code    (snap_code),
    .onehot  (snap_onehot)
  );

  // Two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kmeta <= '0;
      ksync <= '0;
    end else begin
      kmeta <= keys_in;
      ksync <= kmeta;
    end
  end

  // Main FSM with counter, snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      snapshot  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      multi_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ksync != '0) begin
            snapshot <= ksync;
            cnt      <= '0;
            state    <= DEBOUNCE;
            busy     <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (ksync == '0) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (ksync != snapshot) begin
            // Pattern moved: restart the stability window on the new pattern.
            snapshot <= ksync;
            cnt      <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (snap_onehot) begin
              key_code  <= snap_code;
              key_valid <= 1'b1;
              state     <= OFFER;
            end else begin
              multi_err <= 1'b1;
              state     <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OFFER: begin
          // Key lines are ignored here; the event stays until accepted.
          if (key_valid && key_ready) begin
            key_valid <= 1'b0;
            cnt       <= '0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // Need a full window of all-released cycles before re-arming.
          if (ksync != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder with DEBOUNCE_CYCLES=4.
module tb_keypad_encoder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        multi_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_encoder #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_in   (keys_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .multi_err (multi_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the key pattern must be seen identical on D+1 consecutive
  // edges while armed; after an event it disarms until D consecutive released
  // edges follow acceptance (or the error pulse).
  logic [15:0] m_s1, m_s2, m_last;
  int          m_run, m_zero;
  bit          m_armed, m_valid, m_err;
  logic [3:0]  m_code;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_last = '0;
    m_run = 0; m_zero = 0;
    m_armed = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_code = '0;
  endtask

  task automatic model_edge();
    logic [15:0] ks;
    ks    = m_s2;
    m_s2  = m_s1;
    m_s1  = keys_in;
    m_err = 1'b0;
    if (m_valid) begin
      if (key_ready) begin
        m_valid = 1'b0;
        m_zero  = 0;
      end
    end else if (m_armed) begin
      if (ks == '0) m_run = 0;
      else if (m_run > 0 && ks == m_last) m_run++;
      else begin
        m_run  = 1;
        m_last = ks;
      end
      if (m_run == D + 1) begin
        m_armed = 1'b0;
        m_run   = 0;
        m_zero  = 0;
        if ($countones(ks) == 1) begin
          m_valid = 1'b1;
          m_code  = 4'($clog2(ks));
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      if (ks == '0) m_zero++;
      else m_zero = 0;
      if (m_zero == D) m_armed = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model, then compare on the falling edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("key_valid", {31'b0, key_valid}, {31'b0, m_valid});
    chk("multi_err", {31'b0, multi_err}, {31'b0, m_err});
    chk("busy", {31'b0, busy}, {31'b0, m_valid || !m_armed || (m_run > 0)});
    chk("key_code", {28'b0, key_code}, {28'b0, m_code});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int nv, ne;
    rst = 1'b1; keys_in = '0; key_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", {31'b0, key_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, multi_err}, 32'd0);
    chk("rst_code", {28'b0, key_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(3);

    // 1: single key, latency and no repeat while held
    keys_in = 16'h0400; key_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t1_latency", {31'b0, key_valid}, {31'b0, k == 6});
    end
    cycles(8);
    keys_in = '0;
    cycles(8);
    chk("t1_idle", {31'b0, busy}, 32'd0);

    // 2: bouncing key then stable
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      keys_in = ((k / 2) % 2 == 0) ? 16'h0010 : 16'h0000;
      cycle();
      if (key_valid) nv++;
    end
    chk("t2_no_bounce_event", nv, 0);
    keys_in = 16'h0010;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (key_valid) begin
        nv++;
        chk("t2_code", {28'b0, key_code}, 32'h4);
      end
    end
    chk("t2_one_event", nv, 1);
    keys_in = '0;
    cycles(8);

    // 3: two keys at once
    nv = 0; ne = 0;
    keys_in = 16'h0081;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (key_valid) nv++;
      if (multi_err) ne++;
    end
    chk("t3_err_once", ne, 1);
    chk("t3_no_valid", nv, 0);
    keys_in = '0;
    cycles(8);

    // 4: consumer stalls, key released during offer
    keys_in = 16'h8000; key_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) keys_in = '0;
      cycle();
      if (k >= 7) chk("t4_hold", {27'b0, key_valid, key_code}, {27'b0, 1'b1, 4'hF});
    end
    key_ready = 1'b1;
    cycle();
    chk("t4_accepted", {31'b0, key_valid}, 32'd0);
    cycles(8);

    // 5: sweep every code
    for (int i = 0; i < 16; i++) begin
      nv = 0;
      keys_in = 16'(1) << i;
      for (int k = 0; k < 9; k++) begin
        cycle();
        if (key_valid) begin
          nv++;
          chk("t5_code", {28'b0, key_code}, i);
        end
      end
      chk("t5_one_event", nv, 1);
      keys_in = '0;
      cycles(6);
    end

    // 6: reset during offer
    keys_in = 16'h0020; key_ready = 1'b0;
    cycles(9);
    chk("t6_offering", {31'b0, key_valid}, 32'd1);
    keys_in = '0;
    rst = 1'b1;
    #1;
    chk("t6_valid_drop", {31'b0, key_valid}, 32'd0);
    chk("t6_busy_drop", {31'b0, busy}, 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
    key_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (key_valid) nv++;
    end
    chk("t6_no_replay", nv, 0);
    keys_in = 16'h0002;
    cycles(10);
    keys_in = '0;
    cycles(8);

    // Random presses with bounce, random patterns and random ready.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] pat;
      if ($urandom_range(0, 3) == 0) pat = 16'($urandom);
      else pat = 16'(1) << $urandom_range(0, 15);
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
        keys_in   = ($urandom_range(0, 1) == 1) ? pat : 16'($urandom);
        key_ready = 1'($urandom);
        cycle();
      end
      keys_in = pat;
      for (int k = 0; k < int'($urandom_range(3, 14)); k++) begin
        key_ready = 1'($urandom);
        cycle();
      end
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        keys_in   = ($urandom_range(0, 1) == 1) ? pat : 16'h0000;
        key_ready = 1'($urandom);
        cycle();
      end
      keys_in = '0;
      for (int k = 0; k < int'($urandom_range(2, 12)); k++) begin
        key_ready = 1'($urandom);
        cycle();
      end
    end
    key_ready = 1'b1;
    cycles(12);
    chk("final_idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
